data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 22 ++
 rtl/data_mem_arbiter_rr_grant_logic.sv | 42 ++++
 rtl/data_mem_arbiter.sv | 119 +++++++++++
 tb/tb_data_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the two-master data memory arbiter: ownership states,
// master ids and the read-return tag.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  typedef logic mid_t;
  localparam mid_t MID0 = 1'b0;
  localparam mid_t MID1 = 1'b1;

  localparam int BURST_MAX_DEFAULT = 4;

  typedef struct packed {
    logic valid;
    mid_t owner;
  } rtag_t;

endpackage

// File: rtl/data_mem_arbiter_rr_grant_logic.sv
// Combinational grant pick: a sole requester wins; under contention the owner
// keeps the port until its burst is exhausted, then the last-served master yields.
module rr_grant_logic
  import data_mem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic       req0_i,
  input  logic       req1_i,
  input  state_e     state_i,
  input  logic [3:0] cnt_i,
  input  mid_t       rr_ptr_i,
  output logic       gnt0_o,
  output logic       gnt1_o
);

  logic has_owner;
  logic burst_done;

  assign has_owner  = (state_i == OWN0) || (state_i == OWN1);
  assign burst_done = (cnt_i == 4'(BURST_MAX));

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && !req1_i) begin
      gnt0_o = 1'b1;
    end else if (req1_i && !req0_i) begin
      gnt1_o = 1'b1;
    end else if (req0_i && req1_i) begin
      if (has_owner && !burst_done) begin
        gnt0_o = (state_i == OWN0);
        gnt1_o = (state_i == OWN1);
      end else begin
        // Opposite of the last-served master.
        gnt0_o = (rr_ptr_i == MID1);
        gnt1_o = (rr_ptr_i == MID0);
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port registered data memory between the CPU data port
// (master 0) and a loader/debug port (master 1), with bounded bursts.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int N         = 32,
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         m0_req_i,
  input  logic         m0_we_i,
  input  logic [N-1:0] m0_addr_i,
  input  logic [N-1:0] m0_wdata_i,
  output logic         m0_gnt_o,
  output logic         m0_rvalid_o,
  output logic [N-1:0] m0_rdata_o,
  input  logic         m1_req_i,
  input  logic         m1_we_i,
  input  logic [N-1:0] m1_addr_i,
  input  logic [N-1:0] m1_wdata_i,
  output logic         m1_gnt_o,
  output logic         m1_rvalid_o,
  output logic [N-1:0] m1_rdata_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  output logic         mem_we_o,
  input  logic [N-1:0] mem_rdata_i,
  output logic         stall0_o
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  mid_t       rr_q, rr_d;
  rtag_t      tag_q, tag_d;

  logic pick0, pick1;
  logic gnt0, gnt1;

  rr_grant_logic #(.BURST_MAX(BURST_MAX)) u_pick (
    .req0_i   (m0_req_i),
    .req1_i   (m1_req_i),
    .state_i  (state_q),
    .cnt_i    (cnt_q),
    .rr_ptr_i (rr_q),
    .gnt0_o   (pick0),
    .gnt1_o   (pick1)
  );

  // Grants are suppressed while reset is held so nothing reaches memory.
  assign gnt0 = pick0 && !RST;
  assign gnt1 = pick1 && !RST;

  always_comb begin
    state_d = IDLE;
    cnt_d   = 4'd0;
    rr_d    = rr_q;
    tag_d   = '0;
    if (gnt0) begin
      state_d     = OWN0;
      rr_d        = MID0;
      tag_d.valid = !m0_we_i;
      tag_d.owner = MID0;
      if (state_q == OWN0)
        cnt_d = (cnt_q < 4'(BURST_MAX)) ? cnt_q + 4'd1 : cnt_q;
      else
        cnt_d = 4'd1;
    end else if (gnt1) begin
      state_d     = OWN1;
      rr_d        = MID1;
      tag_d.valid = !m1_we_i;
      tag_d.owner = MID1;
      if (state_q == OWN1)
        cnt_d = (cnt_q < 4'(BURST_MAX)) ? cnt_q + 4'd1 : cnt_q;
      else
        cnt_d = 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rr_q    <= MID1;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (gnt0) begin
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
      mem_we_o    = m0_we_i;
    end else if (gnt1) begin
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_we_o    = m1_we_i;
    end
  end

  // A read tag captured just before reset must not surface while reset is held.
  assign m0_rvalid_o = tag_q.valid && (tag_q.owner == MID0) && !RST;
  assign m1_rvalid_o = tag_q.valid && (tag_q.owner == MID1) && !RST;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;
  assign stall0_o = m0_req_i && !gnt0 && !RST;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: reset, single reads, burst rotation,
// write/read contention, alternating reads, owner drop and mid-read reset.
module tb_data_mem_arbiter;

  localparam int N = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [N-1:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic         m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [N-1:0] m0_rdata_o, m1_rdata_o;
  logic [N-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic         mem_we_o, stall0_o;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.N(N), .BURST_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rdata_i(mem_rdata_i), .stall0_o(stall0_o)
  );

  // Inputs change 1ns after a rising edge; outputs are sampled 2ns later.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
    mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    next_cycle();
    next_cycle();
    RST = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    m0_req_i = 1; m0_addr_i = 32'h44; m1_req_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    next_cycle();
    next_cycle();
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_we_o, stall0_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_we_o, stall0_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o, m0_rdata_o, m1_rdata_o} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h rd0 %h rd1 %h want all 0",
               mem_addr_o, mem_wdata_o, m0_rdata_o, m1_rdata_o);
    end
    RST = 0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h10;
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, mem_we_o, stall0_o, mem_addr_o} !== {4'b1000, 32'h10}) begin
      errors++;
      $display("FAIL single_grant: gnt0 %b gnt1 %b we %b stall %b addr %h want 1 0 0 0 00000010",
               m0_gnt_o, m1_gnt_o, mem_we_o, stall0_o, mem_addr_o);
    end
    next_cycle();
    m0_req_i = 0; mem_rdata_i = 32'hCAFE0001;
    #2;
    checks++;
    if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'hCAFE0001}) begin
      errors++;
      $display("FAIL single_rvalid: rvalid %b rdata %h want 1 cafe0001", m0_rvalid_o, m0_rdata_o);
    end
    checks++;
    if ({m1_gnt_o, m1_rvalid_o, m1_rdata_o} !== 34'h0) begin
      errors++;
      $display("FAIL single_m1_quiet: gnt %b rvalid %b rdata %h want 0 0 0", m1_gnt_o, m1_rvalid_o, m1_rdata_o);
    end
    next_cycle();
    #2;
    checks++;
    if ({m0_rvalid_o, m0_rdata_o} !== 33'h0) begin
      errors++;
      $display("FAIL single_rdata_zero: rvalid %b rdata %h want 0 0", m0_rvalid_o, m0_rdata_o);
    end
    idle_inputs();
  endtask

  task automatic test_burst();
    logic [2:0] exp;
    do_reset();
    m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h100; m1_addr_i = 32'h200;
    for (int c = 0; c < 16; c++) begin
      // Ownership rotates every 4 grants starting with m0.
      exp = ((c / 4) % 2 == 0) ? 3'b100 : 3'b011;
      #2;
      checks++;
      if ({m0_gnt_o, m1_gnt_o, stall0_o} !== exp) begin
        errors++;
        $display("FAIL burst_cycle%0d: gnt0/gnt1/stall0 %b want %b", c, {m0_gnt_o, m1_gnt_o, stall0_o}, exp);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_write_contention();
    do_reset();
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h20; m0_wdata_i = 32'h55;
    m1_req_i = 1; m1_addr_i = 32'h30;
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {3'b101, 32'h20, 32'h55}) begin
      errors++;
      $display("FAIL wr_cycle0: gnt0 %b gnt1 %b we %b addr %h wdata %h want 1 0 1 20 55",
               m0_gnt_o, m1_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    next_cycle();
    m0_req_i = 0; m0_we_i = 0;
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, mem_we_o, m0_rvalid_o, m1_rvalid_o, mem_addr_o} !== {5'b01000, 32'h30}) begin
      errors++;
      $display("FAIL wr_cycle1: gnt0 %b gnt1 %b we %b rv0 %b rv1 %b addr %h want 0 1 0 0 0 30",
               m0_gnt_o, m1_gnt_o, mem_we_o, m0_rvalid_o, m1_rvalid_o, mem_addr_o);
    end
    next_cycle();
    m1_req_i = 0; mem_rdata_i = 32'h1234;
    #2;
    checks++;
    if ({m1_rvalid_o, m1_rdata_o, m0_rvalid_o} !== {1'b1, 32'h1234, 1'b0}) begin
      errors++;
      $display("FAIL wr_cycle2: rv1 %b rd1 %h rv0 %b want 1 00001234 0", m1_rvalid_o, m1_rdata_o, m0_rvalid_o);
    end
    idle_inputs();
  endtask

  task automatic test_alternating();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h1;
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      errors++;
      $display("FAIL alt_t0: gnt %b want 10", {m0_gnt_o, m1_gnt_o});
    end
    next_cycle();
    m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h2; mem_rdata_i = 32'hA0A0_0001;
    #2;
    checks++;
    if ({m1_gnt_o, m0_rvalid_o, m0_rdata_o, m1_rvalid_o, m1_rdata_o} !== {2'b11, 32'hA0A0_0001, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL alt_t1: gnt1 %b rv0 %b rd0 %h rv1 %b rd1 %h want 1 1 a0a00001 0 0",
               m1_gnt_o, m0_rvalid_o, m0_rdata_o, m1_rvalid_o, m1_rdata_o);
    end
    next_cycle();
    m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'h3; mem_rdata_i = 32'hB0B0_0002;
    #2;
    checks++;
    if ({m0_gnt_o, m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o} !== {2'b11, 32'hB0B0_0002, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL alt_t2: gnt0 %b rv1 %b rd1 %h rv0 %b rd0 %h want 1 1 b0b00002 0 0",
               m0_gnt_o, m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o);
    end
    next_cycle();
    m0_req_i = 0; mem_rdata_i = 32'hC0C0_0003;
    #2;
    checks++;
    if ({m0_rvalid_o, m0_rdata_o, m1_rvalid_o} !== {1'b1, 32'hC0C0_0003, 1'b0}) begin
      errors++;
      $display("FAIL alt_t3: rv0 %b rd0 %h rv1 %b want 1 c0c00003 0", m0_rvalid_o, m0_rdata_o, m1_rvalid_o);
    end
    idle_inputs();
  endtask

  task automatic test_owner_drop();
    do_reset();
    m0_req_i = 1; m1_req_i = 1;
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      errors++;
      $display("FAIL drop_first: gnt %b want 10", {m0_gnt_o, m1_gnt_o});
    end
    next_cycle();
    m0_req_i = 0;
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, stall0_o} !== 3'b010) begin
      errors++;
      $display("FAIL drop_switch: gnt0/gnt1/stall0 %b want 010", {m0_gnt_o, m1_gnt_o, stall0_o});
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m1_req_i = 1; m1_addr_i = 32'h40;
    #2;
    checks++;
    if (m1_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: gnt1 %b want 1", m1_gnt_o);
    end
    next_cycle();
    RST = 1; m1_req_i = 0; mem_rdata_i = 32'hDEAD_BEEF;
    #2;
    checks++;
    if ({m1_rvalid_o, m1_rdata_o} !== 33'h0) begin
      errors++;
      $display("FAIL rstmid_rvalid: rv1 %b rd1 %h want 0 0", m1_rvalid_o, m1_rdata_o);
    end
    next_cycle();
    RST = 0; m0_req_i = 1; m1_req_i = 1;
    #2;
    checks++;
    if ({m0_gnt_o, m1_gnt_o, m1_rvalid_o} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_contend: gnt0/gnt1/rv1 %b want 100", {m0_gnt_o, m1_gnt_o, m1_rvalid_o});
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    RST = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_burst();
    test_write_contention();
    test_alternating();
    test_owner_drop();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
